// File: rtl/jamma_joy_scanner.sv
// JAMMA multiplexed joystick scanner: a SEL/WAIT/SAMP FSM walks the players and loads a word per player.
// Define JOY_SCAN_DEBOUNCE_EN to debounce each player word; otherwise every sample loads directly.
module jamma_joy_scanner #(
    parameter  int unsigned NUM_PLAYERS = 2,
    parameter  int unsigned JOY_W       = 8,
    parameter  int unsigned SETTLE      = 1,
    parameter  int unsigned DEBOUNCE    = 2,
    localparam int unsigned SW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          pclk,
    input  logic                          Reset_n,
    input  logic                          scan_en,
    input  logic [JOY_W-1:0]              jjoy,
    input  logic [JOY_W-1:0]              local_joy,
    output logic [SW-1:0]                 jselect,
    output logic [NUM_PLAYERS*JOY_W-1:0]  joy_out,
    output logic                          frame_done
);

    localparam int unsigned CW = 4;

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || SETTLE > 15 || DEBOUNCE < 1 || DEBOUNCE > 7
        || JOY_W < 1) begin : g_bad_cfg
        $error("jamma_joy_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SEL  = 2'd0,
        ST_WAIT = 2'd1,
        ST_SAMP = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [SW-1:0]                  idx_q, idx_d;
    logic [CW-1:0]                  wcnt_q, wcnt_d;
    logic                           frame_done_q, frame_done_d;
    logic                           samp_c;
    logic [JOY_W-1:0]               sample_c;
    logic [NUM_PLAYERS*JOY_W-1:0]   joy_q, joy_d;

    // Scan state register; everything holds while scan_en is low.
    always_ff @(posedge pclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_SEL;
            idx_q        <= '0;
            wcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: SEL (1) + WAIT (SETTLE) + SAMP (1) cycles per player.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        samp_c   = 1'b0;
        if (scan_en) begin
            case (state_q)
                ST_SEL: begin
                    wcnt_d  = '0;
                    state_d = (SETTLE > 0) ? ST_WAIT : ST_SAMP;
                end
                ST_WAIT: begin
                    if (wcnt_q == CW'(SETTLE - 1)) begin
                        state_d = ST_SAMP;
                    end
                    wcnt_d = wcnt_q + CW'(1);
                end
                ST_SAMP: begin
                    samp_c  = 1'b1;
                    state_d = ST_SEL;
                    idx_d   = (idx_q == SW'(NUM_PLAYERS - 1)) ? '0 : idx_q + SW'(1);
                end
                default: begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                end
            endcase
        end
        frame_done_d = samp_c && (idx_q == SW'(NUM_PLAYERS - 1));
    end

    assign sample_c = (idx_q == '0) ? (jjoy & local_joy) : jjoy;

`ifdef JOY_SCAN_DEBOUNCE_EN
    localparam int unsigned DW = 3;

    logic [JOY_W-1:0] prev_q [NUM_PLAYERS];
    logic [JOY_W-1:0] prev_d [NUM_PLAYERS];
    logic [DW-1:0]    cnt_q  [NUM_PLAYERS];
    logic [DW-1:0]    cnt_d  [NUM_PLAYERS];

    // Stability counter saturates at DEBOUNCE-1; the word loads whenever it sits there after a sample.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        joy_d  = joy_q;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            if (samp_c && (idx_q == SW'(p))) begin
                prev_d[p] = sample_c;
                if (sample_c != prev_q[p]) begin
                    cnt_d[p] = '0;
                end else if (cnt_q[p] != DW'(DEBOUNCE - 1)) begin
                    cnt_d[p] = cnt_q[p] + DW'(1);
                end
                if (cnt_d[p] == DW'(DEBOUNCE - 1)) begin
                    joy_d[p*JOY_W +: JOY_W] = sample_c;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                prev_q[p] <= '1;
                cnt_q[p]  <= '0;
            end
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // Without debouncing the selected player's word simply follows each sample.
    always_comb begin
        joy_d = joy_q;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            if (samp_c && (idx_q == SW'(p))) begin
                joy_d[p*JOY_W +: JOY_W] = sample_c;
            end
        end
    end
`endif

    always_ff @(posedge pclk or negedge Reset_n) begin
        if (!Reset_n) begin
            joy_q <= '1;
        end else begin
            joy_q <= joy_d;
        end
    end

    assign jselect    = idx_q;
    assign joy_out    = joy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Self-checking bench for jamma_joy_scanner: vector table, directed corner sequences and a
// randomized run against a frame-position / sample-history reference model.
module tb_jamma_joy_scanner;

    localparam int unsigned NP = 2;
    localparam int unsigned ST = 1;
    localparam int unsigned PP = ST + 2;
    localparam int unsigned FR = NP * PP;
`ifdef JOY_SCAN_DEBOUNCE_EN
    localparam int unsigned DEB = 2;
`else
    localparam int unsigned DEB = 1;
`endif

    logic        pclk;
    logic        Reset_n;
    logic        scan_en;
    logic [7:0]  jjoy;
    logic [7:0]  local_joy;
    logic        jselect;
    logic [15:0] joy_out;
    logic        frame_done;
    logic [1:0]  jselect3;
    logic [23:0] joy_out3;
    logic        frame_done3;

    int checks   = 0;
    int failures = 0;

    jamma_joy_scanner u_dut (
        .pclk       (pclk),
        .Reset_n    (Reset_n),
        .scan_en    (scan_en),
        .jjoy       (jjoy),
        .local_joy  (local_joy),
        .jselect    (jselect),
        .joy_out    (joy_out),
        .frame_done (frame_done)
    );

    jamma_joy_scanner #(.NUM_PLAYERS(3), .SETTLE(0)) u_dut3 (
        .pclk       (pclk),
        .Reset_n    (Reset_n),
        .scan_en    (scan_en),
        .jjoy       (jjoy),
        .local_joy  (local_joy),
        .jselect    (jselect3),
        .joy_out    (joy_out3),
        .frame_done (frame_done3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: position within the frame plus a per-player history of samples.
    int          m_pos;
    logic        m_fd;
    logic [15:0] m_joy;
    logic [7:0]  hist [NP][8];
    int          hlen [NP];
    int          m3_pos;
    logic        m3_fd;

    task automatic model_reset();
        m_pos  = 0;
        m_fd   = 1'b0;
        m_joy  = 16'hFFFF;
        m3_pos = 0;
        m3_fd  = 1'b0;
        for (int p = 0; p < int'(NP); p++) begin
            hist[p][0] = 8'hFF;
            hlen[p]    = 1;
        end
    endtask

    task automatic model_edge();
        int         p;
        logic [7:0] s;
        bit         stable;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        m_fd  = 1'b0;
        m3_fd = 1'b0;
        if (scan_en) begin
            if (m_pos % PP == PP - 1) begin
                p = m_pos / PP;
                s = (p == 0) ? (jjoy & local_joy) : jjoy;
                if (hlen[p] < 8) begin
                    hist[p][hlen[p]] = s;
                    hlen[p]++;
                end else begin
                    for (int k = 0; k < 7; k++) hist[p][k] = hist[p][k+1];
                    hist[p][7] = s;
                end
                stable = (hlen[p] >= int'(DEB));
                for (int k = 0; k < int'(DEB); k++)
                    if (hlen[p] - 1 - k >= 0 && hist[p][hlen[p]-1-k] != s) stable = 1'b0;
                if (stable) m_joy[p*8 +: 8] = s;
                m_fd = (p == int'(NP) - 1);
            end
            m_pos = (m_pos + 1) % FR;
            if (m3_pos % 2 == 1) m3_fd = (m3_pos / 2 == 2);
            m3_pos = (m3_pos + 1) % 6;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update model at the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
        chk("model_jselect", 32'(jselect), 32'(m_pos / PP));
        chk("model_joy_out", 32'(joy_out), 32'(m_joy));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
        chk("model_jselect3", 32'(jselect3), 32'(m3_pos / 2));
        chk("model_frame_done3", 32'(frame_done3), 32'(m3_fd));
    endtask

    // Apply reset at a falling edge, check asynchronous effect, release, check first frame.
    task automatic reset_and_check_frame();
        int exp_sel  [7] = '{0, 0, 0, 1, 1, 1, 0};
        int exp_sel3 [7] = '{0, 0, 1, 1, 2, 2, 0};
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_joy_out", 32'(joy_out), 32'hFFFF);
        chk("rst_jselect", 32'(jselect), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_joy_out3", 32'(joy_out3), 32'hFFFFFF);
        step();
        step();
        Reset_n = 1'b1;
        chk("seq_jselect", 32'(jselect), 32'(exp_sel[0]));
        chk("seq_jselect3", 32'(jselect3), 32'(exp_sel3[0]));
        for (int k = 1; k < 7; k++) begin
            step();
            chk("seq_jselect", 32'(jselect), 32'(exp_sel[k]));
            chk("seq_frame_done", 32'(frame_done), 32'(k == 6));
            chk("seq_jselect3", 32'(jselect3), 32'(exp_sel3[k]));
            chk("seq_frame_done3", 32'(frame_done3), 32'(k == 6));
        end
    endtask

    typedef struct {
        logic [7:0]  jj;
        logic [7:0]  lj;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        logic [15:0] snap;
        logic [7:0]  pool [5] = '{8'hFF, 8'hFE, 8'h7F, 8'hEF, 8'h00};
        int          pulses;

        tbl[0] = '{8'hFF, 8'hFF, 16'hFFFF};
        tbl[1] = '{8'hFF, 8'hEF, 16'hFFEF};
        tbl[2] = '{8'h00, 8'hFF, 16'h0000};
        tbl[3] = '{8'hA5, 8'h5A, 16'hA500};
        tbl[4] = '{8'h7E, 8'hFF, 16'h7E7E};

        scan_en   = 1'b1;
        jjoy      = 8'hFF;
        local_joy = 8'hFF;
        Reset_n   = 1'b1;
        @(negedge pclk);
        reset_and_check_frame();

        // Steady-state vectors: two samples per player is enough in either build.
        for (int i = 0; i < 5; i++) begin
            jjoy      = tbl[i].jj;
            local_joy = tbl[i].lj;
            repeat (13) step();
            chk("vec_joy_out", 32'(joy_out), 32'(tbl[i].exp));
            chk("vec_joy_out3", 32'(joy_out3), 32'({tbl[i].jj, tbl[i].jj, tbl[i].jj & tbl[i].lj}));
        end

        // Mid-frame reset from 7E7E clears words at once and restarts at player 0.
        step();
        step();
        chk("pre_rst_joy_out", 32'(joy_out), 32'h7E7E);
        jjoy = 8'hFF;
        reset_and_check_frame();

        // Player 1 alone goes to FE on the shared bus.
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 6; k++) begin
                jjoy = (jselect == 1'b1) ? 8'hFE : 8'hFF;
                step();
            end
            if (round == 0)
                chk("deb_first_samp", 32'(joy_out), (DEB > 1) ? 32'hFFFF : 32'hFEFF);
            else
                chk("deb_second_samp", 32'(joy_out), 32'hFEFF);
        end

        // Pause during the WAIT of player 1, then finish the frame without lost or extra cycles.
        jjoy = 8'hFF;
        repeat (4) step();
        snap    = joy_out;
        scan_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_jselect", 32'(jselect), 32'd1);
            chk("hold_joy_out", 32'(joy_out), 32'(snap));
            chk("hold_frame_done", 32'(frame_done), 32'd0);
        end
        scan_en = 1'b1;
        step();
        chk("resume_samp_fd", 32'(frame_done), 32'd0);
        step();
        chk("resume_fd", 32'(frame_done), 32'd1);
        chk("resume_jselect", 32'(jselect), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            pulses += int'(frame_done);
        end
        chk("resume_pulse_count", 32'(pulses), 32'd1);

        // Randomized run with sticky inputs so debounced words actually settle.
        for (int n = 0; n < 800; n++) begin
            scan_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) jjoy = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) local_joy = pool[$urandom_range(0, 4)];
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
